// File: rtl/riscv_configs.sv
// Shared encodings for the RV32I pipeline control blocks: forwarding selects,
// hazard FSM states and the hardwired-zero register index.
package riscv_configs;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int unsigned X0_IDX = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LUSE  = 2'd1,
    ST_MWAIT = 2'd2
  } hazState_e;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Priority comparator picking the E-stage operand source: M result beats W
// result, and x0 is never forwarded.
module pipe_fwd_sel
  import riscv_configs::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_regwrite_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_w,
  output logic [1:0]        o_sel
);

  logic srcLive;

  assign srcLive = (i_src != REG_AW'(X0_IDX));

  always_comb begin
    o_sel = FWD_RF;
    if (srcLive && i_regwrite_m && (i_rd_m == i_src)) begin
      o_sel = FWD_M;
    end else if (srcLive && i_regwrite_w && (i_rd_w == i_src)) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline: load-use
// bubbles, dmem-wait freeze with sticky watchdog, branch flush.
// Optional performance counters are enabled with `define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import riscv_configs::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs1_d,
  input  logic [REG_AW-1:0] i_rs2_d,
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_regwrite_e,
  input  logic              i_load_e,
  input  logic              i_pcsrc_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_regwrite_m,
  input  logic              i_memreq_m,
  input  logic              i_dmem_ready,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_w,
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_stall_m,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_w,
  output logic [1:0]        o_fwd_a_e,
  output logic [1:0]        o_fwd_b_e,
  output logic              o_mem_timeout,
  output logic              o_busy
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_luse,
  output logic [CNT_W-1:0]  o_cnt_flush,
  output logic [CNT_W-1:0]  o_cnt_mwait
`endif
);

  localparam logic [1:0]  BUBBLE_RELOAD = 2'(LOAD_BUBBLES - 1);
  localparam logic [15:0] TIMEOUT_LIM   = 16'(MEM_TIMEOUT);

  hazState_e   state_q, state_d;
  logic [1:0]  bubbleCnt_q, bubbleCnt_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic        timeout_q, timeout_d;

  logic luse;
  logic memWaitReq;
  logic freeze;
  logic luseBubble;
  logic ctrlFlush;

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src        (i_rs1_e),
    .i_rd_m       (i_rd_m),
    .i_regwrite_m (i_regwrite_m),
    .i_rd_w       (i_rd_w),
    .i_regwrite_w (i_regwrite_w),
    .o_sel        (o_fwd_a_e)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src        (i_rs2_e),
    .i_rd_m       (i_rd_m),
    .i_regwrite_m (i_regwrite_m),
    .i_rd_w       (i_rd_w),
    .i_regwrite_w (i_regwrite_w),
    .o_sel        (o_fwd_b_e)
  );

  assign luse = i_load_e && i_regwrite_e && (i_rd_e != REG_AW'(X0_IDX)) &&
                ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
  assign memWaitReq = i_memreq_m && !i_dmem_ready;

  // Controls are decided from the current state and inputs in the same cycle;
  // a pending bubble count survives a memory wait and is resumed afterwards.
  always_comb begin
    state_d     = state_q;
    bubbleCnt_d = bubbleCnt_q;
    waitCnt_d   = waitCnt_q;
    timeout_d   = timeout_q;
    freeze      = 1'b0;
    luseBubble  = 1'b0;
    ctrlFlush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memWaitReq) begin
          freeze    = 1'b1;
          state_d   = ST_MWAIT;
          waitCnt_d = 16'd1;
        end else if (i_pcsrc_e) begin
          ctrlFlush = 1'b1;
        end else if (luse) begin
          luseBubble = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d     = ST_LUSE;
            bubbleCnt_d = BUBBLE_RELOAD;
          end
        end
      end
      ST_LUSE: begin
        if (memWaitReq) begin
          freeze    = 1'b1;
          state_d   = ST_MWAIT;
          waitCnt_d = 16'd1;
        end else begin
          luseBubble  = 1'b1;
          bubbleCnt_d = bubbleCnt_q - 2'd1;
          if (bubbleCnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MWAIT: begin
        if (!i_dmem_ready) begin
          freeze = 1'b1;
          if (waitCnt_q < TIMEOUT_LIM) begin
            waitCnt_d = waitCnt_q + 16'd1;
          end
        end else begin
          waitCnt_d = 16'd0;
          state_d   = (bubbleCnt_q != 2'd0) ? ST_LUSE : ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (waitCnt_d >= TIMEOUT_LIM) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      bubbleCnt_q <= 2'd0;
      waitCnt_q   <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bubbleCnt_q <= bubbleCnt_d;
      waitCnt_q   <= waitCnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_stall_f     = freeze | luseBubble;
  assign o_stall_d     = freeze | luseBubble;
  assign o_stall_e     = freeze;
  assign o_stall_m     = freeze;
  assign o_flush_d     = ctrlFlush;
  assign o_flush_e     = ctrlFlush | luseBubble;
  assign o_flush_w     = freeze;
  assign o_mem_timeout = timeout_q;
  assign o_busy        = (state_q != ST_RUN);

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] cntLuse_q, cntFlush_q, cntMwait_q;

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cntLuse_q  <= '0;
      cntFlush_q <= '0;
      cntMwait_q <= '0;
    end else begin
      if (luseBubble && (cntLuse_q != {CNT_W{1'b1}})) cntLuse_q <= cntLuse_q + CNT_W'(1);
      if (ctrlFlush && (cntFlush_q != {CNT_W{1'b1}})) cntFlush_q <= cntFlush_q + CNT_W'(1);
      if (freeze && (cntMwait_q != {CNT_W{1'b1}})) cntMwait_q <= cntMwait_q + CNT_W'(1);
    end
  end

  assign o_cnt_luse  = cntLuse_q;
  assign o_cnt_flush = cntFlush_q;
  assign o_cnt_mwait = cntMwait_q;
`else
  // Without the counters the event strobes only drive the stage controls.
`endif

endmodule
